// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register.
// Holds the mode opcodes, FSM state encoding and a mode classifier.
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_LOAD = 3'd5;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// Remaining-shift down-counter.
// Ports: load/init preload, dec steps down, value remaining, last when 1 left.
module shift_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] init,
    output logic [W-1:0] value,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= init;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign last = (value == W'(1));

endmodule

// File: rtl/param_universal_shift_register.sv
// Universal shift register: hold, shift, rotate, load with counted shifts.
// Ports: clk, rst, start/mode/count/pdata/sin in; q, sout, busy, done out.
module param_universal_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] pdata,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e           state;
    state_e           state_nx;
    logic [2:0]       mode_q;
    logic             dir_left;
    logic             accept;
    logic             go_run;
    logic             shift_en;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_last;
    logic [WIDTH-1:0] q_shifted;

    assign accept = (state == IDLE) && start;
    assign go_run = accept && is_shift(mode) && (count != '0);

    // Guarding on a non-zero count keeps q frozen if RUN were ever
    // entered with nothing left to do.
    assign shift_en = (state == RUN) && (cnt_value != '0);

    shift_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (go_run),
        .dec  (state == RUN),
        .init (count),
        .value(cnt_value),
        .last (cnt_last)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (go_run) state_nx = RUN;
            RUN:  if (cnt_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        q_shifted = q;
        unique case (mode_q)
            MODE_SHL: q_shifted = {q[WIDTH-2:0], sin};
            MODE_SHR: q_shifted = {sin, q[WIDTH-1:1]};
            MODE_ROL: q_shifted = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: q_shifted = {q[0], q[WIDTH-1:1]};
            default:  q_shifted = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            mode_q   <= MODE_HOLD;
            dir_left <= 1'b1;
            done     <= 1'b0;
        end else begin
            // Immediate commands finish on acceptance; shifts on the last edge.
            done <= (accept && !go_run) || ((state == RUN) && cnt_last);
            if (accept) begin
                mode_q <= mode;
                if (mode == MODE_SHL || mode == MODE_ROL) begin
                    dir_left <= 1'b1;
                end else if (mode == MODE_SHR || mode == MODE_ROR) begin
                    dir_left <= 1'b0;
                end
                if (mode == MODE_LOAD) begin
                    q <= pdata;
                end
            end else if (shift_en) begin
                q <= q_shifted;
            end
        end
    end

    assign busy = (state == RUN);
    assign sout = dir_left ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Self-checking bench for param_universal_shift_register (WIDTH=8).
// Directed scenarios plus random commands against a behavioural model.
module tb_param_universal_shift_register;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] count;
    logic [7:0] pdata;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int n_run;
    int n_fail;

    logic [7:0] mq;
    logic       mdir;

    param_universal_shift_register #(
        .WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .mode (mode),
        .count(count),
        .pdata(pdata),
        .sin  (sin),
        .q    (q),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_step(input logic [7:0] v,
                                            input int m, input logic s);
        logic [7:0] r;
        r = v;
        case (m)
            1: r = (v << 1) | 8'(s);
            2: r = (v >> 1) | (8'(s) << 7);
            3: r = (v << 1) | (v >> 7);
            4: r = (v >> 1) | (v << 7);
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b1; mode = 3'd5; pdata = 8'hFF; count = 4'd0;
        tick();
        start = 1'b1; mode = 3'd1; count = 4'd3; sin = 1'b1;
        tick();
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_run++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: q=%h busy=%b done=%b want 00 0 0",
                     q, busy, done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        n_run++;
        if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: q=%h sout=%b busy=%b", q, sout, busy);
        end
        mq = 8'h00;
        mdir = 1'b1;
    endtask

    task automatic test_load();
        int busy_seen;
        busy_seen = 0;
        start = 1'b1; mode = 3'd5; pdata = 8'hA5; count = 4'd0;
        tick();
        start = 1'b0;
        if (busy) busy_seen++;
        n_run++;
        if (q !== 8'hA5 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL load: q=%h done=%b want a5 1", q, done);
        end
        tick();
        if (busy) busy_seen++;
        n_run++;
        if (done !== 1'b0 || busy_seen != 0) begin
            n_fail++;
            $display("FAIL load_pulse: done=%b busy_seen=%0d want 0 0",
                     done, busy_seen);
        end
        mq = 8'hA5;
    endtask

    task automatic test_shl();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h4B; exp_q[1] = 8'h97; exp_q[2] = 8'h2F;
        sin = 1'b1;
        start = 1'b1; mode = 3'd1; count = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL shl_busy[%0d]: busy=%b done=%b want 1 0",
                         i, busy, done);
            end
            tick();
            n_run++;
            if (q !== exp_q[i]) begin
                n_fail++;
                $display("FAIL shl_step[%0d]: q=%h want %h", i, q, exp_q[i]);
            end
        end
        n_run++;
        if (busy !== 1'b0 || done !== 1'b1 || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL shl_end: busy=%b done=%b sout=%b want 0 1 0",
                     busy, done, sout);
        end
        mq = 8'h2F;
        mdir = 1'b1;
        tick();
    endtask

    task automatic test_ror();
        int k;
        start = 1'b1; mode = 3'd5; pdata = 8'h81;
        tick();
        start = 1'b1; mode = 3'd4; count = 4'd9;
        tick();
        start = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_run++;
        if (k != 9 || q !== 8'hC0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL ror9: busy_cycles=%0d q=%h done=%b want 9 c0 1",
                     k, q, done);
        end
        mq = 8'hC0;
        mdir = 1'b0;
        tick();
    endtask

    task automatic test_zero_and_ignore();
        int dones;
        logic s;
        start = 1'b1; mode = 3'd2; count = 4'd0;
        tick();
        start = 1'b0;
        n_run++;
        if (q !== mq || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL shr_zero: q=%h done=%b busy=%b want %h 1 0",
                     q, done, busy, mq);
        end
        tick();
        start = 1'b1; mode = 3'd2; count = 4'd5;
        tick();
        start = 1'b0;
        mdir = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dones++;
            if (i == 2) begin
                start = 1'b1; mode = 3'd5; pdata = 8'h00; count = 4'd1;
            end else begin
                start = 1'b0;
            end
            s = 1'($urandom);
            sin = s;
            tick();
            mq = ref_step(mq, 2, s);
        end
        start = 1'b0;
        n_run++;
        if (q !== mq || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_q: q=%h busy=%b want %h 0", q, busy, mq);
        end
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            tick();
        end
        n_run++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignore_done: pulses=%0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        start = 1'b1; mode = 3'd1; count = 4'd5; sin = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_run++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_run: q=%h busy=%b done=%b want 00 0 0",
                     q, busy, done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) dones++;
            tick();
        end
        n_run++;
        if (dones != 0 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_abandon: activity=%0d q=%h want 0 00", dones, q);
        end
        start = 1'b1; mode = 3'd5; pdata = 8'h3C;
        tick();
        start = 1'b0;
        n_run++;
        if (q !== 8'h3C || done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_load: q=%h done=%b want 3c 1", q, done);
        end
        mq = 8'h3C;
        mdir = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        start = 1'b1; mode = 3'd5; pdata = 8'h5A;
        tick();
        n_run++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done1: done=%b want 1", done);
        end
        start = 1'b1; mode = 3'd3; count = 4'd2;
        tick();
        start = 1'b0;
        n_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        tick();
        n_run++;
        if (q !== 8'h69 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rol: q=%h done=%b busy=%b want 69 1 0",
                     q, done, busy);
        end
        start = 1'b1; mode = 3'd5; pdata = 8'h11;
        tick();
        start = 1'b0;
        n_run++;
        if (q !== 8'h11 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_load: q=%h done=%b busy=%b want 11 1 0",
                     q, done, busy);
        end
        mq = 8'h11;
        mdir = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int m;
        int c;
        logic s;
        logic [7:0] pd;
        for (int t = 0; t < 60; t++) begin
            m = int'($urandom_range(0, 7));
            c = int'($urandom_range(0, 12));
            pd = 8'($urandom);
            start = 1'b1; mode = 3'(m); count = 4'(c); pdata = pd;
            tick();
            start = 1'b0;
            if (m == 5) mq = pd;
            if (m == 1 || m == 3) mdir = 1'b1;
            if (m == 2 || m == 4) mdir = 1'b0;
            if (m >= 1 && m <= 4 && c != 0) begin
                for (int i = 0; i < c; i++) begin
                    n_run++;
                    if (busy !== 1'b1 || done !== 1'b0 || q !== mq) begin
                        n_fail++;
                        $display("FAIL rnd_run[%0d.%0d]: busy=%b done=%b q=%h want 1 0 %h",
                                 t, i, busy, done, q, mq);
                    end
                    s = 1'($urandom);
                    sin = s;
                    tick();
                    mq = ref_step(mq, m, s);
                end
            end
            n_run++;
            if (q !== mq || busy !== 1'b0 || done !== 1'b1 ||
                sout !== (mdir ? mq[7] : mq[0])) begin
                n_fail++;
                $display("FAIL rnd_end[%0d] m=%0d c=%0d: q=%h busy=%b done=%b sout=%b want %h 0 1 %b",
                         t, m, c, q, busy, done, sout, mq,
                         (mdir ? mq[7] : mq[0]));
            end
            tick();
            n_run++;
            if (done !== 1'b0 || q !== mq) begin
                n_fail++;
                $display("FAIL rnd_idle[%0d]: done=%b q=%h want 0 %h",
                         t, done, q, mq);
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        mq = 8'h00;
        mdir = 1'b1;
        rst = 1'b1;
        start = 1'b0;
        mode = 3'd0;
        count = 4'd0;
        pdata = 8'h00;
        sin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_load();
        test_shl();
        test_ror();
        test_zero_and_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
